// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: field widths, per-stage bundle layouts and
// the derived bus widths used to size the inter-stage registers.
package cpu_pipe_pkg;

   localparam int XLEN = 32;

   // Control bundle bit offsets
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_REGIN_LO = 4;
   localparam int CTRL_BRANCH   = 6;
   localparam int CTRL_JUMP     = 7;

   typedef struct packed {
      logic       jump;
      logic       branch;
      logic [1:0] regin;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] rv2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
   } ex_mem_data_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_data_t;

   localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
   localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
   localparam int IF_ID_DATA_W  = $bits(if_id_data_t);

   function automatic logic [1:0] count_valid(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+payload storage slot. Clear drops the entry but keeps the
// payload bits; load captures a new entry.
module pipe_entry_reg
   import cpu_pipe_pkg::*;
#(
   parameter int CTRL_W = EX_MEM_CTRL_W,
   parameter int DATA_W = EX_MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic [DATA_W-1:0] data_d, data_q;

   // Next-state selection; clear wins over load
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = d_ctrl;
         data_d  = d_data;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= {CTRL_W{1'b0}};
         data_q  <= {DATA_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional two-entry skid buffer (main entry M, skid entry S).
module pipe_stage_skid
   import cpu_pipe_pkg::*;
#(
   parameter int CTRL_W  = EX_MEM_CTRL_W,
   parameter int DATA_W  = EX_MEM_DATA_W,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
   logic [DATA_W-1:0] m_data, s_data, m_d_data;
   logic              m_load, m_clear, s_load, s_clear;
   logic              in_rdy, accept, consume;

   // Handshake and load/clear steering for both entries
   always_comb begin
      m_load   = 1'b0;
      m_clear  = 1'b0;
      s_load   = 1'b0;
      s_clear  = 1'b0;
      m_d_ctrl = in_ctrl;
      m_d_data = in_data;
      if (SKID_EN) begin
         in_rdy = !s_valid;
      end else begin
         in_rdy = !m_valid | out_ready;
      end
      accept  = in_valid & in_rdy;
      consume = m_valid & out_ready;
      if (flush) begin
         m_clear = 1'b1;
         s_clear = 1'b1;
      end else if (SKID_EN) begin
         if (!m_valid || out_ready) begin
            // S is older than anything at the input, so it drains first
            if (s_valid) begin
               m_load   = 1'b1;
               m_d_ctrl = s_ctrl;
               m_d_data = s_data;
               if (accept) begin
                  s_load = 1'b1;
               end else begin
                  s_clear = 1'b1;
               end
            end else if (accept) begin
               m_load = 1'b1;
            end else begin
               m_clear = 1'b1;
            end
         end else if (accept) begin
            s_load = 1'b1;
         end else begin
            s_load = 1'b0;
         end
      end else begin
         if (accept) begin
            m_load = 1'b1;
         end else if (consume) begin
            m_clear = 1'b1;
         end else begin
            m_load = 1'b0;
         end
      end
   end

   pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (m_clear),
      .load   (m_load),
      .d_ctrl (m_d_ctrl),
      .d_data (m_d_data),
      .valid  (m_valid),
      .ctrl   (m_ctrl),
      .data   (m_data)
   );

   if (SKID_EN) begin : g_skid
      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (s_clear),
         .load   (s_load),
         .d_ctrl (in_ctrl),
         .d_data (in_data),
         .valid  (s_valid),
         .ctrl   (s_ctrl),
         .data   (s_data)
      );
   end else begin : g_no_skid
      assign s_valid = 1'b0;
      assign s_ctrl  = {CTRL_W{1'b0}};
      assign s_data  = {DATA_W{1'b0}};
   end

   assign in_ready  = in_rdy;
   assign out_valid = m_valid;
   assign out_ctrl  = m_valid ? m_ctrl : {CTRL_W{1'b0}};
   assign out_data  = m_data;
   assign occupancy = count_valid(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one skid instance (a) and one
// single-register instance (b), directed vectors with hand-computed results.
module tb_pipe_stage_skid;

   localparam int CW = 8;
   localparam int DW = 160;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [CW-1:0] in_ctrl_a, out_ctrl_a;
   logic [DW-1:0] in_data_a, out_data_a;
   logic [1:0]    occ_a;
   logic          flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [CW-1:0] in_ctrl_b, out_ctrl_b;
   logic [DW-1:0] in_data_b, out_data_b;
   logic [1:0]    occ_b;

   ent_t q_a[$];
   ent_t q_b[$];
   int   checks = 0;
   int   errors = 0;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_ctrl(in_ctrl_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
      .occupancy(occ_a)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_ctrl(in_ctrl_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
      .occupancy(occ_b)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid_a = v;
      in_ctrl_a  = c;
      in_data_a  = d;
   endtask

   task automatic drv_b(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid_b = v;
      in_ctrl_b  = c;
      in_data_b  = d;
   endtask

   // Monitor for instance a: every consumed entry must match the next expected one
   always @(negedge clk) begin
      ent_t e;
      if (rst_n && out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_a_unexpected actual=%0h expected=none", out_data_a);
         end else begin
            e = q_a.pop_front();
            chk("sb_a_data", out_data_a, e.d);
            chk("sb_a_ctrl", DW'(out_ctrl_a), DW'(e.c));
         end
      end
   end

   // Monitor for instance b
   always @(negedge clk) begin
      ent_t e;
      if (rst_n && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_b_unexpected actual=%0h expected=none", out_data_b);
         end else begin
            e = q_b.pop_front();
            chk("sb_b_data", out_data_b, e.d);
            chk("sb_b_ctrl", DW'(out_ctrl_b), DW'(e.c));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      flush_a = 1'b0; out_ready_a = 1'b0; drv_a(1'b0, 8'h00, 160'h0);
      flush_b = 1'b0; out_ready_b = 1'b0; drv_b(1'b0, 8'h00, 160'h0);
      #12 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid_a, 1'b0);
      chk("rst_out_ctrl",  out_ctrl_a, 8'h00);
      chk("rst_out_data",  out_data_a, 160'h0);
      chk("rst_occ",       occ_a, 2'd0);
      chk("rst_in_ready",  in_ready_a, 1'b1);
      chk("rst_b_in_ready", in_ready_b, 1'b1);
      chk("rst_b_valid",   out_valid_b, 1'b0);

      // Streaming 1..8 with out_ready high
      for (int i = 1; i <= 8; i++) begin
         cyc();
         out_ready_a = 1'b1;
         drv_a(1'b1, 8'(i), 160'(i));
         q_a.push_back({8'(i), 160'(i)});
         @(negedge clk);
         chk("stream_in_ready", in_ready_a, 1'b1);
         if (i > 1) begin
            chk("stream_out", out_data_a, 160'(i - 1));
            chk("stream_valid", out_valid_a, 1'b1);
         end
      end
      cyc();
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("stream_last", out_data_a, 160'h8);
      cyc();
      @(negedge clk);
      chk("stream_idle_valid", out_valid_a, 1'b0);
      chk("stream_idle_occ", occ_a, 2'd0);

      // Skid fill: A then B while stalled, a third offer is refused
      cyc();
      out_ready_a = 1'b0;
      drv_a(1'b1, 8'h01, 160'h11);
      q_a.push_back({8'h01, 160'h11});
      @(negedge clk);
      chk("skid_rdy0", in_ready_a, 1'b1);
      chk("skid_occ0", occ_a, 2'd0);
      cyc();
      drv_a(1'b1, 8'h02, 160'h22);
      q_a.push_back({8'h02, 160'h22});
      @(negedge clk);
      chk("skid_occ1", occ_a, 2'd1);
      chk("skid_data1", out_data_a, 160'h11);
      chk("skid_rdy1", in_ready_a, 1'b1);
      cyc();
      drv_a(1'b1, 8'h09, 160'h99);
      @(negedge clk);
      chk("skid_occ2", occ_a, 2'd2);
      chk("skid_rdy2", in_ready_a, 1'b0);
      chk("skid_data2", out_data_a, 160'h11);
      cyc();
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("skid_stable_data", out_data_a, 160'h11);
      chk("skid_stable_ctrl", out_ctrl_a, 8'h01);
      chk("skid_stable_occ", occ_a, 2'd2);
      cyc();
      out_ready_a = 1'b1;
      @(negedge clk);
      chk("skid_drain_a", out_data_a, 160'h11);
      chk("skid_drain_rdy", in_ready_a, 1'b0);
      cyc();
      @(negedge clk);
      chk("skid_drain_b", out_data_a, 160'h22);
      chk("skid_drain_occ", occ_a, 2'd1);
      chk("skid_rdy_back", in_ready_a, 1'b1);
      cyc();
      @(negedge clk);
      chk("skid_empty", out_valid_a, 1'b0);
      chk("skid_empty_occ", occ_a, 2'd0);

      // Flush with two held entries and a simultaneous offer
      cyc();
      out_ready_a = 1'b0;
      drv_a(1'b1, 8'h0C, 160'h44);
      cyc();
      drv_a(1'b1, 8'h0D, 160'h55);
      cyc();
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("flush_pre_occ", occ_a, 2'd2);
      cyc();
      flush_a = 1'b1;
      drv_a(1'b1, 8'h33, 160'h33);
      cyc();
      flush_a = 1'b0;
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("flush_valid", out_valid_a, 1'b0);
      chk("flush_ctrl", out_ctrl_a, 8'h00);
      chk("flush_occ", occ_a, 2'd0);
      chk("flush_rdy", in_ready_a, 1'b1);
      chk("flush_data_kept", out_data_a, 160'h44);

      // Flush while an offer is actually accepted: it must be dropped
      cyc();
      drv_a(1'b1, 8'h0E, 160'h66);
      cyc();
      flush_a = 1'b1;
      drv_a(1'b1, 8'h37, 160'h77);
      @(negedge clk);
      chk("flush_acc_rdy", in_ready_a, 1'b1);
      cyc();
      flush_a = 1'b0;
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("flush_acc_occ", occ_a, 2'd0);
      chk("flush_acc_valid", out_valid_a, 1'b0);
      chk("flush_acc_data", out_data_a, 160'h66);
      cyc();
      out_ready_a = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      chk("flush_no_stray", out_valid_a, 1'b0);

      // Bubble masking of ctrl
      cyc();
      drv_a(1'b1, 8'hFF, 160'hAB);
      q_a.push_back({8'hFF, 160'hAB});
      cyc();
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("bubble_ctrl_ff", out_ctrl_a, 8'hFF);
      chk("bubble_valid1", out_valid_a, 1'b1);
      cyc();
      @(negedge clk);
      chk("bubble_ctrl_0", out_ctrl_a, 8'h00);
      chk("bubble_valid0", out_valid_a, 1'b0);
      chk("bubble_data", out_data_a, 160'hAB);

      // Asynchronous reset with two entries held
      cyc();
      out_ready_a = 1'b0;
      drv_a(1'b1, 8'h21, 160'hA1);
      cyc();
      drv_a(1'b1, 8'h22, 160'hA2);
      cyc();
      drv_a(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("areset_pre_occ", occ_a, 2'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("areset_valid", out_valid_a, 1'b0);
      chk("areset_ctrl", out_ctrl_a, 8'h00);
      chk("areset_data", out_data_a, 160'h0);
      chk("areset_occ", occ_a, 2'd0);
      chk("areset_rdy", in_ready_a, 1'b1);
      #1 rst_n = 1'b1;
      out_ready_a = 1'b1;
      repeat (2) cyc();
      @(negedge clk);
      chk("areset_after", out_valid_a, 1'b0);

      // Single-register variant: streaming
      for (int i = 1; i <= 3; i++) begin
         cyc();
         out_ready_b = 1'b1;
         drv_b(1'b1, 8'(i + 16), 160'(i + 256));
         q_b.push_back({8'(i + 16), 160'(i + 256)});
         @(negedge clk);
         chk("b_stream_rdy", in_ready_b, 1'b1);
      end
      cyc();
      drv_b(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("b_stream_last", out_data_b, 160'h103);

      // Stall makes in_ready drop, then ready returns combinationally
      cyc();
      out_ready_b = 1'b0;
      drv_b(1'b1, 8'h81, 160'h81);
      q_b.push_back({8'h81, 160'h81});
      @(negedge clk);
      chk("b_accept_rdy", in_ready_b, 1'b1);
      cyc();
      drv_b(1'b0, 8'h00, 160'h0);
      #1;
      chk("b_full_rdy", in_ready_b, 1'b0);
      chk("b_full_occ", occ_b, 2'd1);
      out_ready_b = 1'b1;
      drv_b(1'b1, 8'h82, 160'h82);
      #1;
      chk("b_comb_rdy", in_ready_b, 1'b1);
      q_b.push_back({8'h82, 160'h82});
      @(negedge clk);
      chk("b_out_81", out_data_b, 160'h81);
      cyc();
      drv_b(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("b_out_82", out_data_b, 160'h82);
      chk("b_out_82_valid", out_valid_b, 1'b1);
      cyc();
      @(negedge clk);
      chk("b_empty", out_valid_b, 1'b0);

      // Flush on the single-register variant
      cyc();
      out_ready_b = 1'b0;
      drv_b(1'b1, 8'h90, 160'h90);
      cyc();
      flush_b = 1'b1;
      drv_b(1'b0, 8'h00, 160'h0);
      @(negedge clk);
      chk("b_preflush_occ", occ_b, 2'd1);
      cyc();
      flush_b = 1'b0;
      @(negedge clk);
      chk("b_flush_valid", out_valid_b, 1'b0);
      chk("b_flush_occ", occ_b, 2'd0);
      chk("b_flush_ctrl", out_ctrl_b, 8'h00);

      repeat (2) cyc();
      chk("drain_a", 160'(q_a.size()), 160'h0);
      chk("drain_b", 160'(q_b.size()), 160'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
